// File: rtl/shift_mult_pkg.sv
// Shared constants and state type for the shift-and-add multiplier.
// Contents: default operand width, iteration counter width, product width,
//           and the FSM state enum (2-bit encoding).
package shift_mult_pkg;

  localparam int DEF_WIDTH = 11;          // operand width in bits
  localparam int DEF_CNT_W = 4;           // iteration counter width, 2^CNT_W > WIDTH
  localparam int PROD_W    = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_step.sv
// One shift-and-add iteration: conditionally add M into A, then shift {A,Q} right by one.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: a (WIDTH+1), q (WIDTH), m (WIDTH) in; a_next (WIDTH+1), q_next (WIDTH) out.
module shift_add_step
  import shift_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    // Carry is kept in the extra bit so nothing is lost before the shift.
    sum    = a + (q[0] ? {1'b0, m} : '0);
    a_next = {1'b0, sum[WIDTH:1]};
    q_next = {sum[0], q[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: captures X/Y once both loaders are full.
// Latency: WIDTH RUN cycles after the start edge, then the product is held with fp high.
// Backpressure: product held in DONE until p_ack; no restart until fx&&fy has been seen low.
// Ports: clk, rst (sync, active-high); x_par/fx, y_par/fy from loaders; p_ack from serializer;
//        p_par (2*WIDTH, registered), fp (product valid), busy (RUN in progress).
module shift_add_mult
  import shift_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x_par,
  input  logic               fx,
  input  logic [WIDTH-1:0]   y_par,
  input  logic               fy,
  input  logic               p_ack,
  output logic [2*WIDTH-1:0] p_par,
  output logic               fp,
  output logic               busy
);

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             start;
  logic             last_iter;

  assign start     = fx && fy;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_reg),
    .a_next (a_nxt),
    .q_next (q_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)     state_nxt = RUN;
      RUN:      if (last_iter) state_nxt = DONE;
      DONE:     if (p_ack)     state_nxt = WAIT_CLR;
      // Loaders stay full until their own reset; wait for that so one
      // load produces exactly one product.
      WAIT_CLR: if (!start)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
      cnt   <= '0;
      p_par <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= x_par;
            q_reg <= y_par;
            a_reg <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt + 1'b1;
          // Top bit of a_nxt is always zero after the shift, so the low
          // WIDTH bits of A plus Q form the full product.
          if (last_iter) p_par <= {a_nxt[WIDTH-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign fp   = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  localparam int W  = 11;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  x_par, y_par;
  logic          fx, fy, p_ack;
  logic [PW-1:0] p_par;
  logic          fp, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_par (x_par),
    .fx    (fx),
    .y_par (y_par),
    .fy    (fy),
    .p_ack (p_ack),
    .p_par (p_par),
    .fp    (fp),
    .busy  (busy)
  );

  // Reference: product is plain unsigned arithmetic on the captured operands.
  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned r;
    r = longint'(x) * longint'(y);
    return r[PW-1:0];
  endfunction

  // Inputs are driven and outputs sampled at the falling edge. The caller has
  // already presented x/y with fx=fy=1 so that the next rising edge starts the op.
  // busy must be seen for exactly W samples, then fp with the product on the
  // (W+1)th sample; ack is raised on DONE cycle ack_cycle.
  task automatic expect_op(input logic [W-1:0] x, input logic [W-1:0] y, input int ack_cycle);
    logic [PW-1:0] exp_p;
    exp_p = ref_prod(x, y);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b1 || fp !== 1'b0) begin
        fails++;
        $display("FAIL run_cycle%0d x=%0d y=%0d: busy=%b fp=%b, required busy=1 fp=0", k, x, y, busy, fp);
      end
      // Operands after capture must not matter.
      x_par = W'($urandom);
      y_par = W'($urandom);
    end
    for (int d = 1; d <= ack_cycle; d++) begin
      @(negedge clk);
      tests++;
      if (fp !== 1'b1 || busy !== 1'b0 || p_par !== exp_p) begin
        fails++;
        $display("FAIL done_cycle%0d x=%0d y=%0d: fp=%b busy=%b p_par=%0d, required fp=1 busy=0 p_par=%0d",
                 d, x, y, fp, busy, p_par, exp_p);
      end
      if (d == ack_cycle) p_ack = 1'b1;
    end
    @(negedge clk);
    p_ack = 1'b0;
    tests++;
    if (fp !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_ack x=%0d y=%0d: fp=%b busy=%b, required fp=0 busy=0", x, y, fp, busy);
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int ack_cycle);
    x_par = x; y_par = y; fx = 1'b1; fy = 1'b1;
    expect_op(x, y, ack_cycle);
  endtask

  // Loaders drop full for one sampled cycle; block is back in IDLE afterwards.
  task automatic release_loaders();
    fx = 1'b0; fy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; fx = 1'b0; fy = 1'b0; p_ack = 1'b0; x_par = '0; y_par = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || fp !== 1'b0 || p_par !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b fp=%b p_par=%0d, required 0 0 0", busy, fp, p_par);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(11'd5, 11'd3, 3);
    release_loaders();
  endtask

  task automatic test_corners();
    run_op(11'd2047, 11'd2047, 1); release_loaders();
    run_op(11'd0,    11'd1234, 2); release_loaders();
    run_op(11'd1234, 11'd1,    1); release_loaders();
    run_op(11'd1,    11'd2047, 1); release_loaders();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(1, 4)));
      release_loaders();
    end
  endtask

  task automatic test_hold_full();
    logic [W-1:0] x2, y2;
    run_op(11'd77, 11'd99, 1);
    // Loaders remain full: no retrigger.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || fp !== 1'b0) begin
        fails++;
        $display("FAIL hold_full_cycle%0d: busy=%b fp=%b, required 0 0", k, busy, fp);
      end
    end
    fx = 1'b0;
    @(negedge clk);
    x2 = W'($urandom); y2 = W'($urandom);
    x_par = x2; y_par = y2; fx = 1'b1;
    expect_op(x2, y2, 1);
    release_loaders();
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] x, y;
    x = W'($urandom); y = W'($urandom);
    x_par = x; y_par = y; fx = 1'b1; fy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL pre_reset_run%0d: busy=%b, required 1", k, busy);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || fp !== 1'b0 || p_par !== '0) begin
      fails++;
      $display("FAIL mid_run_reset: busy=%b fp=%b p_par=%0d, required 0 0 0", busy, fp, p_par);
    end
    x_par = x; y_par = y;
    expect_op(x, y, 2);
    release_loaders();
  endtask

  task automatic test_ack_held();
    logic [W-1:0] x, y;
    int fp_cnt, busy_cnt;
    logic [PW-1:0] seen;
    p_ack = 1'b1;
    for (int r = 0; r < 2; r++) begin
      x = W'($urandom); y = W'($urandom);
      x_par = x; y_par = y; fx = 1'b1; fy = 1'b1;
      fp_cnt = 0; busy_cnt = 0; seen = '0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (fp) begin fp_cnt++; seen = p_par; end
        if (busy) busy_cnt++;
      end
      tests++;
      if (fp_cnt != 1 || busy_cnt != W || seen !== ref_prod(x, y)) begin
        fails++;
        $display("FAIL ack_held_round%0d: fp_cycles=%0d busy_cycles=%0d p_par=%0d, required 1 %0d %0d",
                 r, fp_cnt, busy_cnt, seen, W, ref_prod(x, y));
      end
      release_loaders();
    end
    p_ack = 1'b0;
  endtask

  task automatic test_fy_low();
    logic [W-1:0] x, y;
    x = W'($urandom); y = W'($urandom);
    x_par = x; y_par = y; fx = 1'b1; fy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || fp !== 1'b0) begin
        fails++;
        $display("FAIL fy_low_cycle%0d: busy=%b fp=%b, required 0 0", k, busy, fp);
      end
    end
    fy = 1'b1;
    expect_op(x, y, 1);
    release_loaders();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_hold_full();
    test_reset_mid_run();
    test_ack_held();
    test_fy_low();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential unsigned shift-and-add multiplier core for the shift multiplier. Sits directly downstream of the serial operand loaders. It waits until both loaders report full (`fx`, `fy`), captures the parallel X and Y words, and computes the 2·WIDTH-bit product in WIDTH iterations. It then holds the product for the output serializer under a valid/ack handshake.

## Interface
- `WIDTH`, 11, operand width in bits (X and Y)
- `CNT_W`, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `x_par`  in  WIDTH  multiplicand from X loader
- `fx`  in  1  X loader full
- `y_par`  in  WIDTH  multiplier from Y loader
- `fy`  in  1  Y loader full
- `p_ack`  in  1  downstream serializer has taken the product
- `p_par`  out  2·WIDTH  product, registered
- `fp`  out  1  product valid
- `busy`  out  1  multiplication in progress

## Operation
- States: IDLE, RUN, DONE, WAIT_CLR.
- IDLE, with `fx && fy` sampled high:
  - M <= x_par; Q <= y_par; A <= 0; cnt <= 0.
  - Go to RUN.
- RUN, each cycle:
  - sum = A + (Q[0] ? M : 0). Sum width is WIDTH+1, so the carry is kept.
  - {A, Q} <= {sum, Q} >> 1; A is WIDTH+1 bits.
  - cnt <= cnt + 1.
- RUN, on the cycle where cnt == WIDTH-1:
  - p_par <= {A_next[WIDTH-1:0], Q_next}.
  - Go to DONE.
- DONE:
  - `fp` = 1. p_par is held.
  - Stay in DONE until `p_ack` is sampled high, then go to WAIT_CLR.
- WAIT_CLR:
  - Stay until `fx && fy` is sampled low, then go to IDLE.
  - This blocks re-triggering on loaders that stay full. The loaders hold full until their own reset.
- Arithmetic: unsigned only. No overflow is possible; the product always fits 2·WIDTH bits.
- Outputs:
  - `busy` = (state == RUN).
  - `fp` = (state == DONE).
  - Both are decoded from registered state, so there is no combinational input→output path.
- `p_par` holds its last product through IDLE, WAIT_CLR and the next RUN. It is only meaningful while `fp` = 1.
- `p_ack` is ignored outside DONE.
- `x_par`/`y_par` changes after capture are ignored.

## Timing
- Reset values, for `rst` high at any edge including mid-RUN:
  - state = IDLE; A, Q, M, cnt = 0.
  - p_par = 0; fp = 0; busy = 0.
  - Reset has priority over every other event.
- Latency: for an edge E that samples `fx && fy` high in IDLE:
  - `busy` is high from E+1 through E+WIDTH, which is 11 cycles.
  - `fp` rises after edge E+WIDTH+1, so the product is valid 12 cycles after E.
- Handshake:
  - `fp` stays high until the edge that samples `p_ack` = 1 in DONE, and falls after that edge.
  - If `p_ack` is already high on the first DONE cycle, `fp` is high for exactly one cycle.
- Minimum restart: after the ack, `fx`/`fy` must go low for at least one sampled cycle before a new IDLE start. IDLE is entered one cycle after the low sample.
- `fx && fy` going low during RUN or DONE has no effect on the current operation.

## Structure
- Package `shift_mult_pkg`:
  - `WIDTH` default and `CNT_W` constants.
  - State enum typedef: IDLE, RUN, DONE, WAIT_CLR; 2-bit encoding.
  - Product-width constant 2·WIDTH.
- Sub-module `shift_add_step`:
  - Combinational single iteration: (A, Q, M) → (A_next, Q_next).
  - The top level holds the FSM, counter and registers.

## Test plan
- X=5, Y=3, both loaders full:
  - `busy` is high for 11 cycles.
  - `fp` rises 12 cycles after the start edge with `p_par` = 15.
  - Ack on the 3rd DONE cycle; `fp` falls after that edge.
- X=2047, Y=2047 → `p_par` = 4190209 (0x3FF001). X=0, Y=1234 → `p_par` = 0. X=1234, Y=1 → `p_par` = 1234.
- `fx`, `fy` held high after the ack:
  - Block stays in WAIT_CLR; no second `busy`.
  - Drop `fx` for one cycle, then raise both again → a new multiplication starts.
- `rst` pulsed on the 6th RUN cycle:
  - Next cycle: `busy` = 0, `fp` = 0, `p_par` = 0.
  - With `fx && fy` still high, the block restarts from IDLE and yields the correct product.
- `p_ack` held high continuously from reset → `fp` is high for exactly one cycle per product.
- `fx` high with `fy` low for 20 cycles → stays in IDLE, `busy` = 0. Asserting `fy` starts the operation on the next edge.
